// File: rtl/prbs_pkg.sv
// Shared types and polynomial table for the multi-pattern PRBS generator.
// Every polynomial is x^len + x^tap + 1 in Fibonacci form.
package prbs_pkg;

  localparam int MAX_LFSR_W = 31;

  typedef enum logic [2:0] {
    PRBS7  = 3'd0,
    PRBS9  = 3'd1,
    PRBS15 = 3'd2,
    PRBS23 = 3'd3,
    PRBS31 = 3'd4
  } prbs_poly_e;

  typedef struct packed {
    logic [4:0] len;
    logic [4:0] tap;
  } poly_cfg_t;

  localparam poly_cfg_t CFG_PRBS7  = '{len: 5'd7,  tap: 5'd6};
  localparam poly_cfg_t CFG_PRBS9  = '{len: 5'd9,  tap: 5'd5};
  localparam poly_cfg_t CFG_PRBS15 = '{len: 5'd15, tap: 5'd14};
  localparam poly_cfg_t CFG_PRBS23 = '{len: 5'd23, tap: 5'd18};
  localparam poly_cfg_t CFG_PRBS31 = '{len: 5'd31, tap: 5'd28};

  // Codes 5..7 fall back to PRBS7 so the tap index is always defined.
  function automatic poly_cfg_t poly_decode(input logic [2:0] sel);
    poly_cfg_t cfg;
    case (sel)
      PRBS9:   cfg = CFG_PRBS9;
      PRBS15:  cfg = CFG_PRBS15;
      PRBS23:  cfg = CFG_PRBS23;
      PRBS31:  cfg = CFG_PRBS31;
      default: cfg = CFG_PRBS7;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/prbs_gen_multi_if.sv
// Control and data bundle of the PRBS generator; master = controller/consumer,
// slave = generator.
interface prbs_gen_multi_if #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 32
);
  logic              en;
  logic [2:0]        poly_sel;
  logic [15:0]       error_rate;
  logic              inject_once;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [DATA_W-1:0] err_flag;
  logic [CNT_W-1:0]  inj_count;

  modport master (
    output en, poly_sel, error_rate, inject_once,
    input  data_out, data_valid, err_flag, inj_count
  );

  modport slave (
    input  en, poly_sel, error_rate, inject_once,
    output data_out, data_valid, err_flag, inj_count
  );
endinterface

// File: rtl/prbs_lfsr_step.sv
// Combinational DATA_W-step unroll of the Fibonacci LFSR; bits[DATA_W-1] is
// the first bit produced. State bits at or above len are don't-care.
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [MAX_LFSR_W-1:0] state,
  input  logic [4:0]            len,
  input  logic [4:0]            tap,
  output logic [MAX_LFSR_W-1:0] state_next,
  output logic [DATA_W-1:0]     bits
);

  always_comb begin
    logic [MAX_LFSR_W-1:0] s;
    logic                  fb;
    s    = state;
    fb   = 1'b0;
    bits = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb      = s[len - 5'd1] ^ s[tap - 5'd1];
      s       = {s[MAX_LFSR_W-2:0], fb};
      bits[i] = fb;
    end
    state_next = s;
  end

endmodule

// File: rtl/prbs_gen_multi.sv
// Runtime-selectable PRBS source, DATA_W bits per clock, with periodic and
// single-shot error injection and a saturating count of inverted bits.
module prbs_gen_multi
  import prbs_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  prbs_gen_multi_if.slave  bus
);

  localparam logic [MAX_LFSR_W-1:0] SEED = '1;

  poly_cfg_t             cfg;
  logic [MAX_LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [DATA_W-1:0]     raw_bits;
  logic [15:0]           cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic [DATA_W-1:0]     err_flag_q, err_flag_d;
  logic                  data_valid_q, data_valid_d;
  logic [CNT_W-1:0]      inj_count_q, inj_count_d;
  logic [2:0]            sel_q, sel_d;
  logic                  sel_seen_q, sel_seen_d;
  logic                  sel_change;

  // The live selection drives decode: after a change cycle sel_q equals it anyway.
  assign cfg        = poly_decode(bus.poly_sel);
  assign sel_change = sel_seen_q && (bus.poly_sel != sel_q);

  prbs_lfsr_step #(.DATA_W(DATA_W)) u_step (
    .state      (lfsr_q),
    .len        (cfg.len),
    .tap        (cfg.tap),
    .state_next (lfsr_step),
    .bits       (raw_bits)
  );

  // NOTE: every variable gets a default first so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [15:0]      c;
    logic             flip;
    logic [CNT_W:0]   inj_sum;
    c            = cnt_q;
    flip         = 1'b0;
    inj_sum      = '0;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q | bus.inject_once;
    data_out_d   = data_out_q;
    err_flag_d   = err_flag_q;
    data_valid_d = 1'b0;
    inj_count_d  = inj_count_q;
    sel_d        = bus.poly_sel;
    sel_seen_d   = 1'b1;

    if (sel_change) begin
      lfsr_d = SEED;
      cnt_d  = 16'd1;
    end else if (bus.en) begin
      lfsr_d = lfsr_step;
      for (int i = DATA_W - 1; i >= 0; i--) begin
        flip = 1'b0;
        if (bus.error_rate == 16'd0) begin
          c = 16'd1;
        end else if (c >= bus.error_rate) begin
          flip = 1'b1;
          c    = 16'd1;
        end else begin
          c = c + 16'd1;
        end
        // A pending single-shot coinciding with a periodic hit flips once only.
        if (i == DATA_W - 1 && pend_q) flip = 1'b1;
        data_out_d[i] = raw_bits[i] ^ flip;
        err_flag_d[i] = flip;
      end
      cnt_d        = c;
      pend_d       = pend_q ? 1'b0 : bus.inject_once;
      data_valid_d = 1'b1;
      inj_sum      = {1'b0, inj_count_q} + (CNT_W + 1)'($countones(err_flag_d));
      inj_count_d  = inj_sum[CNT_W] ? '1 : inj_sum[CNT_W-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q       <= SEED;
      cnt_q        <= 16'd1;
      pend_q       <= 1'b0;
      data_out_q   <= '0;
      err_flag_q   <= '0;
      data_valid_q <= 1'b0;
      inj_count_q  <= '0;
      sel_q        <= 3'd0;
      sel_seen_q   <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      data_out_q   <= data_out_d;
      err_flag_q   <= err_flag_d;
      data_valid_q <= data_valid_d;
      inj_count_q  <= inj_count_d;
      sel_q        <= sel_d;
      sel_seen_q   <= sel_seen_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.err_flag   = err_flag_q;
  assign bus.inj_count  = inj_count_q;

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Self-checking bench: a bit-serial recurrence model (b[n] = b[n-len] ^ b[n-tap])
// with a bits-since-last-flip injection rule, driven by directed and random stimulus.
module tb_prbs_gen_multi;

  localparam int W  = 8;
  localparam int CW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_gen_multi_if #(.DATA_W(W), .CNT_W(CW)) bus ();

  prbs_gen_multi #(.DATA_W(W), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         hist[$];   // hist[0] = most recent bit of the sequence
  int         m_since;   // position of the current bit counted from the last periodic flip
  bit         m_pend, m_valid, m_seen;
  logic [2:0] m_sel;
  logic [W-1:0] m_data, m_err;
  longint     m_inj;
  bit         stream[$]; // DUT bits observed since last reset, in time order

  function automatic int poly_len(input logic [2:0] sel);
    case (sel)
      3'd1: return 9;
      3'd2: return 15;
      3'd3: return 23;
      3'd4: return 31;
      default: return 7;
    endcase
  endfunction

  function automatic int poly_tap(input logic [2:0] sel);
    case (sel)
      3'd1: return 5;
      3'd2: return 14;
      3'd3: return 18;
      3'd4: return 28;
      default: return 6;
    endcase
  endfunction

  task automatic reseed();
    hist = {};
    repeat (31) hist.push_back(1'b1);
  endtask

  task automatic next_bit(input logic [2:0] sel, output bit b);
    b = hist[poly_len(sel) - 1] ^ hist[poly_tap(sel) - 1];
    hist.push_front(b);
    void'(hist.pop_back());
  endtask

  task automatic model_reset();
    reseed();
    m_since = 1; m_pend = 0; m_valid = 0; m_seen = 0; m_sel = 3'd0;
    m_data = '0; m_err = '0; m_inj = 0;
    stream = {};
  endtask

  task automatic model_edge(input bit en, input logic [2:0] sel, input logic [15:0] rate, input bit once);
    bit b, flip, was_pend;
    if (m_seen && sel != m_sel) begin
      reseed();
      m_since = 1;
      m_valid = 0;
      m_pend  = m_pend | once;
    end else if (en) begin
      was_pend = m_pend;
      for (int i = W - 1; i >= 0; i--) begin
        next_bit(sel, b);
        flip = 0;
        if (rate == 0) m_since = 1;
        else if (m_since >= int'(rate)) begin flip = 1; m_since = 1; end
        else m_since++;
        if (i == W - 1 && was_pend) flip = 1;
        m_data[i] = b ^ flip;
        m_err[i]  = flip;
      end
      m_pend  = was_pend ? 1'b0 : once;
      m_valid = 1;
      m_inj   = m_inj + $countones(m_err);
      if (m_inj > 64'h0000_0000_FFFF_FFFF) m_inj = 64'h0000_0000_FFFF_FFFF;
    end else begin
      m_valid = 0;
      m_pend  = m_pend | once;
    end
    m_sel  = sel;
    m_seen = 1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input bit en, input logic [2:0] sel, input logic [15:0] rate, input bit once);
    bus.en = en; bus.poly_sel = sel; bus.error_rate = rate; bus.inject_once = once;
    @(posedge clk);
    model_edge(en, sel, rate, once);
    #1;
    check("data_valid", bus.data_valid, m_valid);
    check("data_out", bus.data_out, m_data);
    check("err_flag", bus.err_flag, m_err);
    check("inj_count", bus.inj_count, m_inj);
    if (bus.data_valid)
      for (int i = W - 1; i >= 0; i--) stream.push_back(bus.data_out[i]);
  endtask

  task automatic do_reset(input logic [2:0] sel, input logic [15:0] rate);
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0; bus.poly_sel = sel; bus.error_rate = rate; bus.inject_once = 1'b0;
    model_reset();
    #1;
    check("rst_data_out", bus.data_out, 0);
    check("rst_err_flag", bus.err_flag, 0);
    check("rst_data_valid", bus.data_valid, 0);
    check("rst_inj_count", bus.inj_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_prbs7_head(input string tag);
    logic [6:0] head;
    for (int i = 0; i < 7; i++) head[6 - i] = stream[i];
    check(tag, head, 7'b0000001);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, mism, err_total;
    logic [15:0] rate;
    logic [2:0]  sel;
    bit en, once;
    logic [15:0] rate_tab [6];
    rate_tab = '{16'd0, 16'd1, 16'd3, 16'd7, 16'd13, 16'd100};

    bus.en = 0; bus.poly_sel = 0; bus.error_rate = 0; bus.inject_once = 0;
    model_reset();

    // PRBS7, no injection: head, weight, period.
    do_reset(3'd0, 16'd0);
    repeat (40) cycle(1, 3'd0, 16'd0, 0);
    check_prbs7_head("prbs7_head");
    ones = 0;
    for (int i = 0; i < 127; i++) ones += int'(stream[i]);
    check("prbs7_ones", ones, 64);
    mism = 0;
    for (int i = 0; i + 127 < stream.size(); i++) if (stream[i] != stream[i + 127]) mism++;
    check("prbs7_period", mism, 0);
    check("prbs7_inj", bus.inj_count, 0);

    // PRBS31, error_rate=100, 8000 bits.
    do_reset(3'd4, 16'd100);
    err_total = 0;
    repeat (1000) begin
      cycle(1, 3'd4, 16'd100, 0);
      err_total += $countones(bus.err_flag);
    end
    check("prbs31_err_total", err_total, 80);
    check("prbs31_inj", bus.inj_count, 80);

    // Live error_rate reduction, then a single-shot pulse on an idle cycle.
    do_reset(3'd0, 16'd1000);
    repeat (63) cycle(1, 3'd0, 16'd1000, 0);
    check("rate_hold_inj", bus.inj_count, 0);
    cycle(1, 3'd0, 16'd200, 0);
    check("rate_drop_flip", bus.err_flag, 8'h80);
    repeat (60) cycle(1, 3'd0, 16'd200, 0);
    cycle(0, 3'd0, 16'd200, 1);
    cycle(0, 3'd0, 16'd200, 0);
    cycle(1, 3'd0, 16'd200, 0);
    check("once_msb", bus.err_flag[W-1], 1'b1);
    repeat (10) cycle(1, 3'd0, 16'd200, 0);

    // poly_sel change 0->2, then invalid code 6 behaves as PRBS7.
    do_reset(3'd0, 16'd0);
    repeat (10) cycle(1, 3'd0, 16'd0, 0);
    cycle(1, 3'd2, 16'd0, 0);
    check("sw15_gap", bus.data_valid, 1'b0);
    cycle(1, 3'd2, 16'd0, 0);
    check("sw15_word0", bus.data_out, 8'h00);
    cycle(1, 3'd2, 16'd0, 0);
    check("sw15_word1", bus.data_out[7:1], 7'b0000001);
    repeat (5) cycle(1, 3'd2, 16'd0, 0);
    cycle(1, 3'd6, 16'd0, 0);
    check("sw6_gap", bus.data_valid, 1'b0);
    cycle(1, 3'd6, 16'd0, 0);
    check("sw6_word0", bus.data_out, 8'h02);
    repeat (40) cycle(1, 3'd6, 16'd0, 0);

    // Randomized traffic: en, rate, polynomial and idle-cycle single shots.
    do_reset(3'd0, 16'd0);
    sel = 3'd0; rate = 16'd0;
    repeat (400) begin
      en = ($urandom_range(0, 4) != 0);
      once = !en && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) rate = rate_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 29) == 0) sel = 3'($urandom_range(0, 7));
      cycle(en, sel, rate, once);
    end

    // Asynchronous reset pulse in the middle of a cycle during traffic.
    do_reset(3'd0, 16'd10);
    repeat (20) cycle(1, 3'd0, 16'd10, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_data", bus.data_out, 0);
    check("async_rst_valid", bus.data_valid, 0);
    check("async_rst_err", bus.err_flag, 0);
    check("async_rst_inj", bus.inj_count, 0);
    #2;
    rst_n = 1'b1;
    repeat (40) cycle(1, 3'd0, 16'd0, 0);
    check_prbs7_head("restart_head");
    check("restart_inj", bus.inj_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
